// File: rtl/sa_result_drain.sv
// Ping-pong result-matrix capture and row-per-beat drain for the systolic array.
// Optional SA_DRAIN_RELU_EN clamps negative output elements to zero on the output mux.
module sa_result_drain #(
    parameter int unsigned D_W = 16,
    parameter int unsigned S   = 16,
    parameter int unsigned C   = 16
) (
    input  logic                                  I_CLK,
    input  logic                                  I_RST,
    input  logic                                  I_MAT_VLD,
    input  logic [S*C*D_W-1:0]                    I_MAT,
    output logic                                  O_MAT_RDY,
    output logic                                  O_ROW_VLD,
    input  logic                                  I_ROW_RDY,
    output logic [C*D_W-1:0]                      O_ROW,
    output logic [((S > 1) ? $clog2(S) : 1)-1:0]  O_ROW_IDX,
    output logic                                  O_ROW_LAST,
    output logic                                  O_OVF,
    input  logic                                  I_OVF_CLR
);

    localparam int unsigned ROW_W = C * D_W;
    localparam int unsigned MAT_W = S * ROW_W;
    localparam int unsigned RW    = (S > 1) ? $clog2(S) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      full_q, full_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [RW-1:0]   row_cnt_q, row_cnt_d;
    logic            ovf_q, ovf_d;
    logic [MAT_W-1:0] bank0_q, bank1_q;
    logic [1:0]      cap_c;
    logic            mat_rdy_c;
    logic            vld_c;
    logic            last_c;
    logic [MAT_W-1:0] sel_bank_c;
    logic [ROW_W-1:0] row_raw_c;
    logic [ROW_W-1:0] row_out_c;

    // Acceptance looks only at pre-edge flags; a freshly released bank waits one cycle.
    assign mat_rdy_c = !full_q[wr_ptr_q];
    assign vld_c     = (state_q == ST_STREAM);
    assign last_c    = vld_c && (row_cnt_q == RW'(S - 1));

    always_comb begin
        state_d   = state_q;
        full_d    = full_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        row_cnt_d = row_cnt_q;
        ovf_d     = ovf_q;
        cap_c     = 2'b00;

        if (I_MAT_VLD && mat_rdy_c) begin
            cap_c[wr_ptr_q]  = 1'b1;
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
        end

        if (I_OVF_CLR) begin
            ovf_d = 1'b0;
        end
        if (I_MAT_VLD && !mat_rdy_c) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_ptr_q]) begin
                    state_d   = ST_STREAM;
                    row_cnt_d = '0;
                end
            end
            ST_STREAM: begin
                if (I_ROW_RDY) begin
                    if (last_c) begin
                        // Chain straight into the other bank only if it was already full.
                        full_d[rd_ptr_q] = 1'b0;
                        rd_ptr_d         = ~rd_ptr_q;
                        row_cnt_d        = '0;
                        state_d          = full_q[~rd_ptr_q] ? ST_STREAM : ST_IDLE;
                    end else begin
                        row_cnt_d = row_cnt_q + RW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q   <= ST_IDLE;
            full_q    <= 2'b00;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            row_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            row_cnt_q <= row_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            bank0_q <= '0;
            bank1_q <= '0;
        end else begin
            if (cap_c[0]) bank0_q <= I_MAT;
            if (cap_c[1]) bank1_q <= I_MAT;
        end
    end

    // Row select from the bank being drained.
    always_comb begin
        sel_bank_c = rd_ptr_q ? bank1_q : bank0_q;
        row_raw_c  = '0;
        for (int r = 0; r < int'(S); r++) begin
            if (RW'(r) == row_cnt_q) begin
                row_raw_c = sel_bank_c[r*ROW_W +: ROW_W];
            end
        end
    end

`ifdef SA_DRAIN_RELU_EN
    always_comb begin
        row_out_c = row_raw_c;
        for (int c = 0; c < int'(C); c++) begin
            if (row_raw_c[c*D_W + D_W - 1]) begin
                row_out_c[c*D_W +: D_W] = '0;
            end
        end
    end
`else
    assign row_out_c = row_raw_c;
`endif

    assign O_MAT_RDY  = mat_rdy_c;
    assign O_ROW_VLD  = vld_c;
    assign O_ROW      = row_out_c;
    assign O_ROW_IDX  = row_cnt_q;
    assign O_ROW_LAST = last_c;
    assign O_OVF      = ovf_q;

endmodule
